// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master engine.
// State encoding, slot and quarter indices, operation codes.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_DATA_W,
    ST_DATA_R,
    ST_HOLD,
    ST_RSTART,
    ST_STOP
  } i2c_state_e;

  localparam logic [3:0] SLOT_ACK = 4'd8;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

endpackage

// File: rtl/i2c_qtr_tick.sv
// SCL quarter-period timebase for the I2C engine.
// Ticks every CLK_DIV clocks and tracks the quarter index.
module i2c_qtr_tick #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       restart_i,
  output logic       tick_o,
  output logic [1:0] qtr_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    qtr_q, qtr_d;

  assign tick_o = (cnt_q == CNT_MAX);
  assign qtr_o  = qtr_q;

  // Advance the divider; restart realigns to quarter 0.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    qtr_d = qtr_q;
    if (restart_i) begin
      cnt_d = '0;
      qtr_d = 2'd0;
    end else if (tick_o) begin
      cnt_d = '0;
      qtr_d = qtr_q + 2'd1;
    end
  end

  // Divider and quarter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      qtr_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      qtr_q <= qtr_d;
    end
  end

endmodule

// File: rtl/i2c_master_engine.sv
// Bit-level I2C master: START, address byte, one data byte,
// then STOP or HOLD for a repeated START.
module i2c_master_engine
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       Start,
  input  logic       Stop,
  input  logic       repeat_start,
  input  logic       mode,
  input  logic [6:0] address,
  input  logic [7:0] register,
  input  logic       reset_I2C,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack,
  output logic [7:0] data_out
);

  i2c_state_e state_q, state_d;
  logic [3:0] slot_q, slot_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic [7:0] wdata_q, wdata_d;
  logic [6:0] addr_q, addr_d;
  logic       mode_q, mode_d;
  logic       stop_q, stop_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ack_q, ack_d;
  logic       capture;
  logic       restart;
  logic       tick;
  logic [1:0] qtr;
  logic       sample;
  logic       slot_end;

  i2c_qtr_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk_i    (clk),
    .rst_ni   (reset),
    .restart_i(restart),
    .tick_o   (tick),
    .qtr_o    (qtr)
  );

  assign sample   = tick && (qtr == Q1);
  assign slot_end = tick && (qtr == Q3);
  assign restart  = (state_d != state_q) || reset_I2C;

  assign busy     = busy_q;
  assign done     = done_q;
  assign ack      = ack_q;
  assign data_out = data_q;

  // Next-state, shifting and status update.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    shift_d = shift_q;
    data_d  = data_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    stop_d  = stop_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ack_d   = ack_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en && Start) begin
          capture = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START, ST_RSTART: begin
        if (slot_end) begin
          state_d = ST_ADDR;
          shift_d = {addr_q, mode_q};
        end
      end
      ST_ADDR, ST_DATA_W: begin
        if (sample && slot_q == SLOT_ACK && sda_in) begin
          ack_d = 1'b0;
        end
        if (slot_end) begin
          if (slot_q != SLOT_ACK) begin
            slot_d  = slot_q + 4'd1;
            shift_d = {shift_q[6:0], 1'b0};
          end else if (state_q == ST_DATA_W) begin
            if (stop_q) begin
              state_d = ST_STOP;
            end else begin
              state_d = ST_HOLD;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end else if (!ack_q) begin
            state_d = ST_STOP;
          end else if (mode_q == OP_READ) begin
            state_d = ST_DATA_R;
          end else begin
            state_d = ST_DATA_W;
            shift_d = wdata_q;
          end
        end
      end
      ST_DATA_R: begin
        if (sample && slot_q != SLOT_ACK) begin
          shift_d = {shift_q[6:0], sda_in};
        end
        if (slot_end) begin
          if (slot_q != SLOT_ACK) begin
            slot_d = slot_q + 4'd1;
          end else begin
            data_d = shift_q;
            if (stop_q) begin
              state_d = ST_STOP;
            end else begin
              state_d = ST_HOLD;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end
        end
      end
      ST_HOLD: begin
        if (Stop || !en) begin
          state_d = ST_STOP;
          busy_d  = 1'b1;
        end else if (repeat_start) begin
          capture = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_RSTART;
        end
      end
      ST_STOP: begin
        if (slot_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (capture) begin
      addr_d  = address;
      mode_d  = mode;
      wdata_d = register;
      stop_d  = Stop;
      ack_d   = 1'b1;
    end
    if (state_d != state_q) begin
      slot_d = 4'd0;
    end
    if (reset_I2C) begin
      state_d = ST_IDLE;
      slot_d  = 4'd0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      ack_d   = 1'b0;
    end
  end

  // Pin drive decoded from state, quarter and current bit.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    unique case (state_q)
      ST_START: begin
        scl_oe = (qtr == Q3);
        sda_oe = (qtr == Q2) || (qtr == Q3);
      end
      ST_RSTART: begin
        scl_oe = (qtr == Q0) || (qtr == Q3);
        sda_oe = (qtr == Q2) || (qtr == Q3);
      end
      ST_ADDR, ST_DATA_W: begin
        scl_oe = (qtr == Q0) || (qtr == Q3);
        sda_oe = (slot_q != SLOT_ACK) && !shift_q[7];
      end
      ST_DATA_R: begin
        scl_oe = (qtr == Q0) || (qtr == Q3);
      end
      ST_HOLD: begin
        scl_oe = 1'b1;
        sda_oe = 1'b1;
      end
      ST_STOP: begin
        scl_oe = (qtr == Q0);
        sda_oe = (qtr == Q0) || (qtr == Q1);
      end
      default: begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
      end
    endcase
  end

  // Engine state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      slot_q  <= 4'd0;
      shift_q <= 8'd0;
      data_q  <= 8'd0;
      wdata_q <= 8'd0;
      addr_q  <= 7'd0;
      mode_q  <= 1'b0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

endmodule
